// File: rtl/seq_gen_ctrl.sv
// seq_gen_ctrl: programmable serial sequence generator.
// Accepts a pattern descriptor (pattern, length, repeat count) over a valid/ready
// config port and streams the pattern MSB-first on a valid/ready output port,
// once per repetition, with no gap between repetitions. All outputs decode from
// registered state, so no input reaches an output combinationally.
module seq_gen_ctrl #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // A bit index only has to address PAT_W positions.
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] len_m1;
  logic [REP_W-1:0] rep_cnt;
  logic             err_q;

  logic cfg_bad;
  logic cfg_take;
  logic xfer;
  logic final_bit;

  assign cfg_bad   = (cfg_len == '0) || (cfg_len > PAT_W_L) || (cfg_reps == '0);
  assign cfg_take  = (state == IDLE) && cfg_valid && !cfg_bad;
  assign xfer      = (state == RUN) && dout_ready;
  assign final_bit = (bit_idx == '0) && (rep_cnt == REP_ONE);

  // Next-state decode: abort wins over a completing transfer, so an aborted
  // run never reports done.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cfg_take) state_nx = RUN;
      RUN: begin
        if (abort)                  state_nx = IDLE;
        else if (xfer && final_bit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Descriptor latch, bit/repeat counters and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      bit_idx <= '0;
      len_m1  <= '0;
      rep_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && cfg_valid && cfg_bad;
      if (cfg_take) begin
        pat_q   <= cfg_pattern;
        bit_idx <= IDX_W'(cfg_len - 1'b1);
        len_m1  <= IDX_W'(cfg_len - 1'b1);
        rep_cnt <= cfg_reps;
      end else if (xfer && !abort) begin
        if (bit_idx != '0) begin
          bit_idx <= bit_idx - 1'b1;
        end else if (rep_cnt > REP_ONE) begin
          rep_cnt <= rep_cnt - 1'b1;
          bit_idx <= len_m1;
        end
      end
    end
  end

  // Outputs are gated by state so they read 0 outside a run.
  assign cfg_ready  = (state == IDLE);
  assign dout_valid = (state == RUN);
  assign dout       = (state == RUN) && pat_q[bit_idx];
  assign dout_last  = (state == RUN) && final_bit;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Scoreboard bench for seq_gen_ctrl: each accepted descriptor pushes its
// expected {bit,last} beats; the monitor pops one per transfer and compares.
module tb_seq_gen_ctrl;
  localparam int PAT_W = 16;
  localparam int LEN_W = 5;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             rst, cfg_valid, cfg_ready, abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [REP_W-1:0] cfg_reps;
  logic             dout, dout_valid, dout_ready, dout_last, busy, done, err;

  seq_gen_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_reps(cfg_reps),
    .abort(abort), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int done_cnt = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle 1,0,1,0
  logic [1:0] exp_q[$];  // {bit, last}

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // dout_ready driver, changes just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) dout_ready = 1'b1;
    else                 dout_ready = ~dout_ready;
  end

  // Monitor: pop/compare on each transfer, check stall stability, count done.
  logic prev_stall = 1'b0;
  logic prev_dout = 1'b0, prev_last = 1'b0;
  always @(negedge clk) begin
    if (!rst && dout_valid && prev_stall) begin
      chk("stall_dout", dout, prev_dout);
      chk("stall_last", dout_last, prev_last);
    end
    if (!rst && dout_valid && dout_ready) begin
      beats++;
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("sb_dout", dout, e[1]);
        chk("sb_last", dout_last, e[0]);
      end
    end
    if (done) done_cnt++;
    prev_stall = !rst && dout_valid && !dout_ready;
    prev_dout  = dout;
    prev_last  = dout_last;
  end

  task automatic push_exp(input logic [PAT_W-1:0] pat, input int len, input int reps);
    for (int r = 0; r < reps; r++)
      for (int b = len - 1; b >= 0; b--)
        exp_q.push_back({pat[b], (r == reps - 1) && (b == 0)});
  endtask

  // Present a descriptor for one edge (caller is just after a rising edge).
  task automatic send(input logic [PAT_W-1:0] pat, input int len, input int reps, input bit legal);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_reps    = REP_W'(reps);
    cfg_valid   = 1'b1;
    if (legal) push_exp(pat, len, reps);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int b0, d0;
    rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0; dout_ready = 1'b1;
    cfg_pattern = '0; cfg_len = '0; cfg_reps = '0;
    do_reset();
    @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;

    // 1: continuous stream, 12 consecutive valid cycles then done.
    b0 = beats;
    send(16'h000B, 6, 2, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_valid", dout_valid, 1);
    end
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_valid_off", dout_valid, 0);
    chk("t1_ready_in_done", cfg_ready, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_ready_back", cfg_ready, 1);
    chk("t1_beats", beats - b0, 12);
    chk("t1_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // 2: same descriptor with a toggling consumer.
    ready_mode = 1;
    b0 = beats;
    send(16'h000B, 6, 2, 1);
    wait_done("t2", 80);
    chk("t2_beats", beats - b0, 12);
    chk("t2_q_empty", exp_q.size(), 0);
    ready_mode = 0;
    @(posedge clk); #1;

    // 3: illegal descriptors rejected with an err pulse each.
    for (int k = 0; k < 3; k++) begin
      int ln, rp;
      ln = (k == 0) ? 0 : (k == 1) ? 17 : 4;
      rp = (k == 2) ? 0 : 3;
      send(16'h1234, ln, rp, 0);
      @(negedge clk);
      chk("t3_err", err, 1);
      chk("t3_busy", busy, 0);
      chk("t3_valid", dout_valid, 0);
      chk("t3_ready", cfg_ready, 1);
      @(negedge clk);
      chk("t3_err_pulse", err, 0);
      @(posedge clk); #1;
    end

    // 4: abort after 5 beats, then an immediate new run.
    b0 = beats; d0 = done_cnt;
    send(16'hFFFF, 16, 3, 1);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t4_beats", beats - b0, 5);
    chk("t4_ready", cfg_ready, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", dout_valid, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_q_left", exp_q.size(), 43);
    exp_q.delete();
    @(posedge clk); #1;
    b0 = beats;
    send(16'h0005, 3, 1, 1);
    @(negedge clk);
    chk("t4_new_valid", dout_valid, 1);
    wait_done("t4_new", 20);
    chk("t4_new_beats", beats - b0, 3);

    // 5: single-bit pattern, then reset in the middle of a run.
    b0 = beats;
    send(16'h0001, 1, 4, 1);
    wait_done("t5", 20);
    chk("t5_beats", beats - b0, 4);
    chk("t5_q_empty", exp_q.size(), 0);
    send(16'h00A5, 8, 2, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", cfg_ready, 1);
    chk("t5_rst_valid", dout_valid, 0);
    chk("t5_rst_dout", dout, 0);
    chk("t5_rst_last", dout_last, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_err", err, 0);
    exp_q.delete();
    @(posedge clk); #1;

    // 6: cfg_valid held through the run gives exactly one run.
    b0 = beats; d0 = done_cnt;
    cfg_pattern = 16'h0005; cfg_len = 5'd3; cfg_reps = 8'd2; cfg_valid = 1'b1;
    push_exp(16'h0005, 3, 2);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 40) begin @(negedge clk); n++; end
      chk("t6_done_seen", done, 1);
      cfg_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("t6_beats", beats - b0, 6);
    chk("t6_one_done", done_cnt - d0, 1);
    chk("t6_idle", busy, 0);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
